lc3b_mem_bridge: RTL and testbench

Memory-side neighbour of the LC-3b datapath. Takes the CPU memory request (word address from MAR, store data from MDR, read/write strobes and byte enables from control) and runs it against a word-wide physical memory with variable latency. Partial (byte) stores become read-modify-write sequences. The block returns a one-cycle `mem_resp` with registered read data for MDR.

---
 rtl/lc3b_types.sv | 23 ++
 rtl/lc3b_byte_merge.sv | 19 +
 rtl/lc3b_mem_bridge.sv | 141 ++++++++++++++
 tb/tb_lc3b_mem_bridge.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the memory bridge and its byte-merge helper.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_be;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    DONE     = 3'd4
  } lc3b_mem_state;

  localparam lc3b_mem_be BE_NONE = 2'b00;
  localparam lc3b_mem_be BE_FULL = 2'b11;

  // Expands per-byte enables into a per-bit lane mask.
  function automatic lc3b_word lane_mask(input lc3b_mem_be be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/lc3b_byte_merge.sv
// Combinational byte-lane merge: enabled lanes from the new word, the rest from the old word.
module lc3b_byte_merge
  import lc3b_types::*;
(
  input  lc3b_word   i_old_word,
  input  lc3b_word   i_new_word,
  input  lc3b_mem_be i_be,
  output lc3b_word   o_merged
);

  lc3b_word w_mask;

  // Lane select driven by the byte-enable mask.
  always_comb begin
    w_mask   = lane_mask(i_be);
    o_merged = (i_new_word & w_mask) | (i_old_word & ~w_mask);
  end

endmodule

// File: rtl/lc3b_mem_bridge.sv
// Bridges LC-3b CPU memory requests to a word-wide variable-latency physical memory,
// turning partial stores into read-modify-write sequences.
module lc3b_mem_bridge
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [1:0]       mem_byte_enable,
  input  logic [WIDTH-1:0] mem_address,
  input  logic [WIDTH-1:0] mem_wdata,
  output logic [WIDTH-1:0] mem_rdata,
  output logic             mem_resp,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [WIDTH-1:0] pmem_address,
  output logic [WIDTH-1:0] pmem_wdata,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp
);

  lc3b_mem_state    r_state, w_next_state;
  logic [WIDTH-1:0] r_addr, w_addr;
  logic [WIDTH-1:0] r_wdata, w_wdata;
  lc3b_mem_be       r_be, w_be;
  logic [WIDTH-1:0] r_pmem_wdata, w_pmem_wdata;
  logic [WIDTH-1:0] r_mem_rdata, w_mem_rdata;
  logic             r_mem_resp, w_mem_resp;
  logic             r_pmem_read, w_pmem_read;
  logic             r_pmem_write, w_pmem_write;
  lc3b_word         w_merged;

  lc3b_byte_merge u_merge (
    .i_old_word (pmem_rdata),
    .i_new_word (r_wdata),
    .i_be       (r_be),
    .o_merged   (w_merged)
  );

  // State register and registered outputs; reset drops every strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr       <= {WIDTH{1'b0}};
      r_wdata      <= {WIDTH{1'b0}};
      r_be         <= BE_NONE;
      r_pmem_wdata <= {WIDTH{1'b0}};
      r_mem_rdata  <= {WIDTH{1'b0}};
      r_mem_resp   <= 1'b0;
      r_pmem_read  <= 1'b0;
      r_pmem_write <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_addr       <= w_addr;
      r_wdata      <= w_wdata;
      r_be         <= w_be;
      r_pmem_wdata <= w_pmem_wdata;
      r_mem_rdata  <= w_mem_rdata;
      r_mem_resp   <= w_mem_resp;
      r_pmem_read  <= w_pmem_read;
      r_pmem_write <= w_pmem_write;
    end
  end

  // Next-state and next-register logic; strobes are decoded from the next state
  // so they behave as Moore outputs of the state being entered.
  always_comb begin
    w_next_state = r_state;
    w_addr       = r_addr;
    w_wdata      = r_wdata;
    w_be         = r_be;
    w_pmem_wdata = r_pmem_wdata;
    w_mem_rdata  = r_mem_rdata;

    case (r_state)
      IDLE: begin
        if (mem_write || mem_read) begin
          w_addr  = mem_address & {{(WIDTH-1){1'b1}}, 1'b0};
          w_wdata = mem_wdata;
          w_be    = mem_byte_enable;
        end else begin
          w_addr  = r_addr;
        end
        if (mem_write) begin
          if (mem_byte_enable == BE_FULL) begin
            w_next_state = WRITE;
            w_pmem_wdata = mem_wdata;
          end else if (mem_byte_enable == BE_NONE) begin
            w_next_state = DONE;
          end else begin
            w_next_state = RMW_READ;
          end
        end else if (mem_read) begin
          w_next_state = READ;
        end else begin
          w_next_state = IDLE;
        end
      end
      READ: begin
        if (pmem_resp) begin
          w_mem_rdata  = pmem_rdata;
          w_next_state = DONE;
        end else begin
          w_next_state = READ;
        end
      end
      RMW_READ: begin
        if (pmem_resp) begin
          w_pmem_wdata = w_merged;
          w_next_state = WRITE;
        end else begin
          w_next_state = RMW_READ;
        end
      end
      WRITE: begin
        if (pmem_resp) begin
          w_next_state = DONE;
        end else begin
          w_next_state = WRITE;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase

    w_pmem_read  = (w_next_state == READ) || (w_next_state == RMW_READ);
    w_pmem_write = (w_next_state == WRITE);
    w_mem_resp   = (w_next_state == DONE);
  end

  assign mem_rdata    = r_mem_rdata;
  assign mem_resp     = r_mem_resp;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_addr;
  assign pmem_wdata   = r_pmem_wdata;

endmodule

// File: tb/tb_lc3b_mem_bridge.sv
// Randomized self-checking bench for lc3b_mem_bridge with a word-array memory model.
module tb_lc3b_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic        mem_resp, pmem_read, pmem_write;
  logic [15:0] pmem_address, pmem_wdata, pmem_rdata;
  logic        pmem_resp;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] mem [int];
  logic [15:0] exp_rdata = 16'h0000;

  lc3b_mem_bridge #(.WIDTH(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_address    (pmem_address),
    .pmem_wdata      (pmem_wdata),
    .pmem_rdata      (pmem_rdata),
    .pmem_resp       (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_get(input int wa);
    if (!mem.exists(wa)) mem[wa] = 16'($urandom);
    return mem[wa];
  endfunction

  // One CPU transaction with the bench acting as physical memory.
  task automatic run_txn(input logic rd, input logic wr, input logic [1:0] be,
                         input logic [15:0] addr, input logic [15:0] wd,
                         input int lat1, input int lat2);
    int wa, exp_cyc, cyc, rd_s, wr_s, n_rd, n_wr, lat;
    bit is_byte, is_none, done;
    logic [15:0] old_word, exp_word, exp_addr;
    wa       = int'(addr) / 2;
    exp_addr = 16'(wa * 2);
    is_byte  = wr && (be == 2'b01 || be == 2'b10);
    is_none  = wr && (be == 2'b00);
    old_word = mem_get(wa);
    exp_word = wd;
    if (is_byte && be == 2'b10) exp_word = {wd[15:8], old_word[7:0]};
    if (is_byte && be == 2'b01) exp_word = {old_word[15:8], wd[7:0]};
    exp_cyc = is_none ? 1 : (is_byte ? lat1 + lat2 + 1 : lat1 + 1);
    cyc = 0; rd_s = 0; wr_s = 0; n_rd = 0; n_wr = 0; done = 1'b0;

    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_byte_enable = be;
    mem_address = addr; mem_wdata = wd; pmem_resp = 1'b0;

    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      pmem_resp   = 1'b0;
      pmem_rdata  = 16'($urandom);
      mem_address = 16'($urandom);
      mem_wdata   = 16'($urandom);
      mem_byte_enable = 2'($urandom);
      if (pmem_read && pmem_write) check_eq("strobe_excl", 32'd1, 32'd0);
      if (mem_resp) begin
        done = 1'b1;
        if (!wr) exp_rdata = mem[wa];
        check_eq("latency", cyc, exp_cyc);
        check_eq("mem_rdata", mem_rdata, exp_rdata);
        check_eq("n_pmem_rd", n_rd, (!wr || is_byte) ? 1 : 0);
        check_eq("n_pmem_wr", n_wr, (wr && !is_none) ? 1 : 0);
        mem_read = 1'b0; mem_write = 1'b0;
        pmem_resp = 1'($urandom);
      end else if (pmem_read) begin
        if (rd_s == 0) n_rd++;
        check_eq("rd_addr", pmem_address, exp_addr);
        rd_s++;
        if (rd_s >= lat1) begin
          pmem_resp  = 1'b1;
          pmem_rdata = mem[wa];
          rd_s = 0;
        end
      end else if (pmem_write) begin
        if (wr_s == 0) n_wr++;
        check_eq("wr_addr", pmem_address, exp_addr);
        check_eq("wr_data", pmem_wdata, exp_word);
        wr_s++;
        lat = is_byte ? lat2 : lat1;
        if (wr_s >= lat) begin
          pmem_resp = 1'b1;
          mem[wa]   = exp_word;
          wr_s = 0;
        end
      end
    end
    if (!done) begin
      check_eq("timeout", cyc, exp_cyc);
      mem_read = 1'b0; mem_write = 1'b0;
    end
    @(negedge clk);
    pmem_resp = 1'b0;
    check_eq("resp_pulse", {mem_resp, pmem_read, pmem_write}, 3'b000);
  endtask

  // Idle cycles with stray pmem_resp pulses that must be ignored.
  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("idle_quiet", {mem_resp, pmem_read, pmem_write}, 3'b000);
      check_eq("idle_rdata", mem_rdata, exp_rdata);
      pmem_resp  = 1'($urandom);
      pmem_rdata = 16'($urandom);
    end
    @(negedge clk);
    pmem_resp = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 2'b00;
    mem_address = 16'h0000; mem_wdata = 16'h0000;
    pmem_rdata = 16'h0000; pmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs", {mem_resp, pmem_read, pmem_write}, 3'b000);
    check_eq("rst_rdata", mem_rdata, 16'h0000);
    check_eq("rst_paddr", pmem_address, 16'h0000);
    check_eq("rst_pwdata", pmem_wdata, 16'h0000);
    reset = 1'b0;
    idle_gap(2);

    mem[32'h3000 / 2] = 16'hBEEF;
    run_txn(1'b1, 1'b0, 2'b00, 16'h3001, 16'h0000, 3, 0);
    run_txn(1'b0, 1'b1, 2'b11, 16'h0040, 16'h1234, 2, 0);
    check_eq("full_wr_mem", mem[32'h0040 / 2], 16'h1234);
    mem[32'h0100 / 2] = 16'h5566;
    run_txn(1'b0, 1'b1, 2'b10, 16'h0100, 16'hAB00, 1, 2);
    check_eq("be10_mem", mem[32'h0100 / 2], 16'hAB66);
    mem[32'h0100 / 2] = 16'h5566;
    run_txn(1'b0, 1'b1, 2'b01, 16'h0101, 16'h00CD, 2, 1);
    check_eq("be01_mem", mem[32'h0100 / 2], 16'h55CD);
    run_txn(1'b0, 1'b1, 2'b00, 16'h0100, 16'hFFFF, 1, 1);
    run_txn(1'b1, 1'b1, 2'b11, 16'h0200, 16'h7777, 1, 0);
    run_txn(1'b1, 1'b0, 2'b00, 16'h0201, 16'h0000, 1, 0);
    check_eq("rw_both_rd", mem_rdata, 16'h7777);

    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = $urandom_range(0, 3);
      run_txn(kind != 1, kind == 1 || kind == 2, 2'($urandom),
              16'h4000 + 16'($urandom_range(0, 31)), 16'($urandom),
              $urandom_range(1, 4), $urandom_range(1, 4));
      idle_gap($urandom_range(0, 2));
    end

    // Reset while a read waits on physical memory.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 16'h5002;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_read", pmem_read, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst_drop_rd", {pmem_read, mem_resp}, 2'b00);
    check_eq("rst_mid_rdata", mem_rdata, 16'h0000);
    mem_read = 1'b0;
    exp_rdata = 16'h0000;
    repeat (2) @(negedge clk);
    check_eq("rst_no_resp", mem_resp, 1'b0);
    reset = 1'b0;
    idle_gap(1);
    run_txn(1'b1, 1'b0, 2'b00, 16'h5002, 16'h0000, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
